rsd_result_checker: RTL and testbench

- Downstream consumer of the redundant signed-digit (RSD) adder result, in the pll_clock domain, alongside the C-path delays.
- Converts each adder sum (DIGITS+1 RSD digits) to a two's-complement value, one digit per cycle, MSD first.
- Compares that value with a golden expected value supplied with it, and accumulates pass/fail statistics for the test control unit.

---
 rtl/add_tester_pkg.sv | 28 ++
 rtl/rsd_digit_decode.sv | 19 +
 rtl/rsd_result_checker.sv | 164 ++++++++++++++++
 tb/tb_rsd_result_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_tester_pkg.sv
// Shared types and derived-width helpers for the RSD adder result checker.
// Used by rsd_result_checker and rsd_digit_decode.
package add_tester_pkg;

  localparam int ERR_COUNT_W  = 16;
  localparam int TEST_COUNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Bits per RSD digit: magnitude bits plus a sign bit.
  function automatic int calc_dw(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int calc_d_out(input int digits);
    return digits + 1;
  endfunction

  // Signed width that holds RADIX^(DIGITS+1)-1 without overflow.
  function automatic int calc_vw(input int radix, input int digits);
    return $clog2(radix) * (digits + 1) + 1;
  endfunction

endpackage

// File: rtl/rsd_digit_decode.sv
// Combinational RSD digit decoder: sign-extends one two's-complement digit
// and flags the single encodable value outside [-(RADIX-1), RADIX-1].
module rsd_digit_decode
  import add_tester_pkg::*;
#(
  parameter int RADIX = 2,
  parameter int VW    = 17,
  localparam int DW   = calc_dw(RADIX)
) (
  input  logic [DW-1:0] digit,
  output logic [VW-1:0] value,
  output logic          illegal
);

  assign value   = {{(VW-DW){digit[DW-1]}}, digit};
  // Only -RADIX (sign bit alone) is representable yet outside the legal range.
  assign illegal = (digit == {1'b1, {(DW-1){1'b0}}});

endmodule

// File: rtl/rsd_result_checker.sv
// Serial RSD-to-binary converter and golden-value checker with statistics.
// Optional macro RSD_CHECK_LAST_ERR_EN adds last_err_valid/last_err_addr.
module rsd_result_checker
  import add_tester_pkg::*;
#(
  parameter int  RADIX      = 2,
  parameter int  DIGITS     = 15,
  parameter int  ADDR_WIDTH = 11,
  localparam int D_OUT      = calc_d_out(DIGITS),
  localparam int DW         = calc_dw(RADIX),
  localparam int VW         = calc_vw(RADIX, DIGITS)
) (
  input  logic                    pll_clock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DW*D_OUT-1:0]     in_sum,
  input  logic [VW-1:0]           in_expected,
  output logic                    busy,
  output logic                    res_valid,
  output logic                    res_pass,
  output logic [VW-1:0]           res_value,
  output logic [TEST_COUNT_W-1:0] test_count,
  output logic [ERR_COUNT_W-1:0]  err_count,
  output logic                    first_err_valid,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
`ifdef RSD_CHECK_LAST_ERR_EN
  output logic                    last_err_valid,
  output logic [ADDR_WIDTH-1:0]   last_err_addr,
`endif
  output logic                    illegal_digit_seen
);

  localparam int LOG2R = $clog2(RADIX);
  localparam int IDX_W = (D_OUT > 1) ? $clog2(D_OUT) : 1;

  state_t                  state_q, state_d;
  logic [DW*D_OUT-1:0]     sum_q;
  logic [VW-1:0]           expected_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [VW-1:0]           acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    bad_q;

  logic [DW-1:0]           digit;
  logic [VW-1:0]           digit_ext;
  logic                    digit_bad;
  logic [VW-1:0]           acc_next;
  logic                    vec_fail;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign digit    = sum_q[DW*idx_q +: DW];
  // Multiply by RADIX is a shift; wrap on illegal digits is harmless.
  assign acc_next = (acc_q << LOG2R) + digit_ext;
  assign vec_fail = (acc_q != expected_q) | bad_q;

  rsd_digit_decode #(
    .RADIX (RADIX),
    .VW    (VW)
  ) u_decode (
    .digit   (digit),
    .value   (digit_ext),
    .illegal (digit_bad)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (idx_q == '0) state_d = CMP;
      CMP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      sum_q      <= '0;
      expected_q <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      res_value  <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state_q)
        IDLE: if (in_valid) begin
          sum_q      <= in_sum;
          expected_q <= in_expected;
          addr_q     <= in_addr;
          acc_q      <= '0;
          idx_q      <= IDX_W'(D_OUT - 1);
          bad_q      <= 1'b0;
        end
        CONV: begin
          acc_q <= acc_next;
          idx_q <= idx_q - 1'b1;
          if (digit_bad) bad_q <= 1'b1;
        end
        CMP: begin
          res_valid <= 1'b1;
          res_pass  <= ~vec_fail;
          res_value <= acc_q;
        end
        default: ;
      endcase
    end
  end

  // Statistics; clear overrides any update in the same cycle.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      test_count         <= '0;
      err_count          <= '0;
      first_err_valid    <= 1'b0;
      first_err_addr     <= '0;
      illegal_digit_seen <= 1'b0;
`ifdef RSD_CHECK_LAST_ERR_EN
      last_err_valid     <= 1'b0;
      last_err_addr      <= '0;
`endif
    end else if (clear) begin
      test_count         <= '0;
      err_count          <= '0;
      first_err_valid    <= 1'b0;
      first_err_addr     <= '0;
      illegal_digit_seen <= 1'b0;
`ifdef RSD_CHECK_LAST_ERR_EN
      last_err_valid     <= 1'b0;
      last_err_addr      <= '0;
`endif
    end else begin
      if (state_q == CONV && digit_bad) illegal_digit_seen <= 1'b1;
      if (state_q == CMP) begin
        test_count <= test_count + 1'b1;
        if (vec_fail) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= addr_q;
          end
`ifdef RSD_CHECK_LAST_ERR_EN
          last_err_valid <= 1'b1;
          last_err_addr  <= addr_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rsd_result_checker.sv
// Scoreboard bench for rsd_result_checker (RADIX=2, DIGITS=15, VW=17).
// Also covers RSD_CHECK_LAST_ERR_EN when that macro is defined.
module tb_rsd_result_checker;

  logic        pll_clock = 1'b0;
  logic        resetn    = 1'b0;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [10:0] in_addr   = '0;
  logic [31:0] in_sum    = '0;
  logic [16:0] in_expected = '0;
  logic        busy;
  logic        res_valid;
  logic        res_pass;
  logic [16:0] res_value;
  logic [31:0] test_count;
  logic [15:0] err_count;
  logic        first_err_valid;
  logic [10:0] first_err_addr;
  logic        illegal_digit_seen;
`ifdef RSD_CHECK_LAST_ERR_EN
  logic        last_err_valid;
  logic [10:0] last_err_addr;
`endif

  typedef struct {
    logic [16:0] value;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 pll_clock = ~pll_clock;

  rsd_result_checker #(
    .RADIX      (2),
    .DIGITS     (15),
    .ADDR_WIDTH (11)
  ) dut (
    .pll_clock          (pll_clock),
    .resetn             (resetn),
    .clear              (clear),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_addr            (in_addr),
    .in_sum             (in_sum),
    .in_expected        (in_expected),
    .busy               (busy),
    .res_valid          (res_valid),
    .res_pass           (res_pass),
    .res_value          (res_value),
    .test_count         (test_count),
    .err_count          (err_count),
    .first_err_valid    (first_err_valid),
    .first_err_addr     (first_err_addr),
`ifdef RSD_CHECK_LAST_ERR_EN
    .last_err_valid     (last_err_valid),
    .last_err_addr      (last_err_addr),
`endif
    .illegal_digit_seen (illegal_digit_seen)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result strobe must match the oldest scoreboard entry.
  always @(negedge pll_clock) begin
    if (resetn && res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_value", 64'(res_value), 64'(e.value));
        check("res_pass", 64'(res_pass), 64'(e.pass));
      end
    end
  end

  task automatic send(input logic [31:0] sum, input logic [16:0] exp_v, input logic [10:0] addr,
                      input logic [16:0] model_v, input logic model_pass, input bit track);
    int n = 0;
    @(negedge pll_clock);
    while (!in_ready && n < 100) begin
      @(negedge pll_clock);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 64'd0, 64'd1);
    in_valid    = 1'b1;
    in_sum      = sum;
    in_expected = exp_v;
    in_addr     = addr;
    @(posedge pll_clock);
    if (track) sb.push_back('{value: model_v, pass: model_pass});
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge pll_clock);
      n++;
    end
    @(negedge pll_clock);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int accepts;
    int cyc;
    int first_cyc;
    int prev_cyc;
    int bad_gap;
    int ready_busy_bad;
    int strobes;

    repeat (3) @(posedge pll_clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_test_count", 64'(test_count), 64'd0);
    @(negedge pll_clock) resetn = 1'b1;

    // 1: all-zero sum, latency of 17 edges
    send(32'h0, 17'h0, 11'd5, 17'h0, 1'b1, 1'b1);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge pll_clock);
      #1;
      if (res_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 64'(lat), 64'd17);
    check("t1_test_count", 64'(test_count), 64'd1);
    wait_done();

    // 2: digit0=+1, digit1=-1 -> -1
    send(32'h0000_000D, 17'h1FFFF, 11'd6, 17'h1FFFF, 1'b1, 1'b1);
    wait_done();
    check("t2_err_count", 64'(err_count), 64'd0);

    // 3: all +1 -> 65535 mismatches 65534; second fail keeps first address
    send(32'h5555_5555, 17'd65534, 11'h2A, 17'h0FFFF, 1'b0, 1'b1);
    wait_done();
    check("t3_err_count", 64'(err_count), 64'd1);
    check("t3_first_valid", 64'(first_err_valid), 64'd1);
    check("t3_first_addr", 64'(first_err_addr), 64'h2A);
    send(32'h0, 17'd1, 11'd3, 17'h0, 1'b0, 1'b1);
    wait_done();
    check("t3b_err_count", 64'(err_count), 64'd2);
    check("t3b_first_addr", 64'(first_err_addr), 64'h2A);
    check("t3b_test_count", 64'(test_count), 64'd4);
`ifdef RSD_CHECK_LAST_ERR_EN
    check("t3b_last_valid", 64'(last_err_valid), 64'd1);
    check("t3b_last_addr", 64'(last_err_addr), 64'd3);
`endif

    // 4: illegal digit7 = -2 -> arithmetic -256 but must fail
    check("t4_illegal_before", 64'(illegal_digit_seen), 64'd0);
    send(32'h0000_8000, 17'h1FF00, 11'd9, 17'h1FF00, 1'b0, 1'b1);
    wait_done();
    check("t4_illegal_seen", 64'(illegal_digit_seen), 64'd1);
    check("t4_err_count", 64'(err_count), 64'd3);

    // 5: in_valid held high -> one accept every 18 cycles
    accepts = 0; cyc = 0; first_cyc = 0; prev_cyc = 0; bad_gap = 0; ready_busy_bad = 0;
    @(negedge pll_clock);
    in_valid = 1'b1; in_sum = '0; in_expected = '0; in_addr = 11'd12;
    while (accepts < 4 && cyc < 300) begin
      if (in_ready == busy) ready_busy_bad++;
      if (in_ready) begin
        if (accepts > 0 && cyc - prev_cyc != 18) bad_gap++;
        if (accepts == 0) first_cyc = cyc;
        prev_cyc = cyc;
        accepts++;
        @(posedge pll_clock);
        sb.push_back('{value: 17'h0, pass: 1'b1});
        if (accepts == 4) #1 in_valid = 1'b0;
        @(negedge pll_clock);
      end else begin
        @(negedge pll_clock);
      end
      cyc++;
    end
    check("t5_accepts", 64'(accepts), 64'd4);
    check("t5_gap", 64'(bad_gap), 64'd0);
    check("t5_span", 64'(prev_cyc - first_cyc), 64'd54);
    check("t5_ready_vs_busy", 64'(ready_busy_bad), 64'd0);
    wait_done();
    check("t5_test_count", 64'(test_count), 64'd9);

    // 6a: reset mid-conversion aborts without a result
    send(32'h5555_5555, 17'd0, 11'd4, 17'h0, 1'b0, 1'b0);
    repeat (5) @(posedge pll_clock);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check("t6_rst_test_count", 64'(test_count), 64'd0);
    check("t6_rst_err_count", 64'(err_count), 64'd0);
    check("t6_rst_first_valid", 64'(first_err_valid), 64'd0);
    check("t6_rst_illegal", 64'(illegal_digit_seen), 64'd0);
    @(negedge pll_clock) resetn = 1'b1;
    strobes = 0;
    repeat (25) begin
      @(negedge pll_clock);
      if (res_valid) strobes++;
    end
    check("t6_no_strobe", 64'(strobes), 64'd0);

    // 6b: clear on the same edge as a failing compare
    send(32'h0, 17'h0, 11'd1, 17'h0, 1'b1, 1'b1);
    wait_done();
    check("t6_pre_test_count", 64'(test_count), 64'd1);
    send(32'h0, 17'd5, 11'd7, 17'h0, 1'b0, 1'b1);
    repeat (16) @(posedge pll_clock);
    #1 clear = 1'b1;
    @(posedge pll_clock);
    #1 clear = 1'b0;
    check("t6_clear_res_valid", 64'(res_valid), 64'd1);
    check("t6_clear_err_count", 64'(err_count), 64'd0);
    check("t6_clear_test_count", 64'(test_count), 64'd0);
    check("t6_clear_first_valid", 64'(first_err_valid), 64'd0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
